// File: rtl/me_pkg.sv
// Shared sizes and helpers for the full-search block-matching motion estimator.
package me_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned REF_DIM      = 16;
  localparam int unsigned WIN_DIM      = 32;
  localparam int unsigned NUM_PE       = 16;
  localparam int unsigned BLOCK_CYCLES = 256;
  localparam int unsigned SCAN_CYCLES  = 4096;
  localparam int unsigned RUN_CYCLES   = 4112;
  localparam int unsigned CNT_W        = 13;
  localparam int unsigned MV_W         = 4;
  localparam int unsigned RADDR_W      = $clog2(REF_DIM * REF_DIM);
  localparam int unsigned SADDR_W      = $clog2(WIN_DIM * WIN_DIM);

  localparam logic [PIX_W-1:0] DIST_MAX = 8'hFF;

  // Unsigned absolute difference of two pixels.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? PIX_W'(a - b) : PIX_W'(b - a);
  endfunction

endpackage

// File: rtl/me_pe.sv
// One processing element: accumulates |a-b| into a saturating 8-bit SAD.
module me_pe
  import me_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] acc
);

  logic [PIX_W-1:0] diff;
  logic [PIX_W:0]   sum;

  assign diff = abs_diff(a, b);
  assign sum  = {1'b0, acc} + {1'b0, diff};

  // First window cycle loads, later cycles add with saturation at 255.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      if (load)            acc <= diff;
      else if (sum[PIX_W]) acc <= DIST_MAX;
      else                 acc <= sum[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/motion_estimator.sv
// Full-search motion estimator: 16-PE systolic SAD array over 16 vertical blocks.
module motion_estimator
  import me_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [RADDR_W-1:0] AddressR,
  input  logic [PIX_W-1:0]   R,
  output logic [SADDR_W-1:0] AddressS1,
  input  logic [PIX_W-1:0]   S1,
  output logic [SADDR_W-1:0] AddressS2,
  input  logic [PIX_W-1:0]   S2,
  output logic [PIX_W-1:0]   BestDist,
  output logic [MV_W-1:0]    motionX,
  output logic [MV_W-1:0]    motionY
);

  logic [CNT_W-1:0] count;
  logic             in_scan;
  logic             in_run;
  logic [3:0]       dy_idx;
  logic [3:0]       row_i;
  logic [3:0]       col_t;
  logic [7:0]       prev_row;
  logic [4:0]       row1;
  logic [4:0]       row2;
  logic             cmp_valid;
  logic [3:0]       cmp_k;
  logic [3:0]       cmp_dy;
  logic [PIX_W-1:0] cand;
  logic [PIX_W-1:0] r_dly [NUM_PE-1];
  logic [PIX_W-1:0] acc   [NUM_PE];

  assign in_scan = (count < CNT_W'(SCAN_CYCLES));
  assign in_run  = (count < CNT_W'(RUN_CYCLES));
  assign dy_idx  = count[11:8];
  assign row_i   = count[7:4];
  assign col_t   = count[3:0];

  // S2 fetches the right half of the row scanned 16 cycles earlier.
  assign prev_row = count[11:4] - 8'd1;
  assign row1     = 5'(dy_idx) + 5'(row_i);
  assign row2     = 5'(prev_row[7:4]) + 5'(prev_row[3:0]);

  assign AddressR  = in_scan ? count[7:0] : '0;
  assign AddressS1 = in_scan ? {row1, 1'b0, col_t} : '0;
  // S2 keeps addressing through the drain so the last block's wrapped columns arrive.
  assign AddressS2 = in_run ? {row2, 1'b1, col_t} : '0;

  // Reference delay line: tap k carries R from k cycles ago.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int m = 0; m < NUM_PE - 1; m++) r_dly[m] <= '0;
    end else if (start) begin
      r_dly[0] <= R;
      for (int m = 1; m < NUM_PE - 1; m++) r_dly[m] <= r_dly[m-1];
    end
  end

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    logic [CNT_W-1:0] rel;
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic             en;
    logic             load;

    assign rel  = count - CNT_W'(k);
    assign en   = start && (count >= CNT_W'(k)) && (rel < CNT_W'(SCAN_CYCLES));
    assign load = (rel[7:0] == 8'd0);
    assign b    = (col_t >= 4'(k)) ? S1 : S2;

    if (k == 0) begin : g_tap0
      assign a = R;
    end else begin : g_tapn
      assign a = r_dly[k-1];
    end

    me_pe u_pe (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .load  (load),
      .a     (a),
      .b     (b),
      .acc   (acc[k])
    );
  end

  // PE k of block dy finishes one cycle before count = (dy+1)*256 + k.
  assign cmp_k     = count[3:0];
  assign cmp_dy    = 4'(count[12:8] - 5'd1);
  assign cmp_valid = (count >= CNT_W'(BLOCK_CYCLES)) && in_run && (count[7:4] == 4'd0);
  assign cand      = acc[cmp_k];

  // Run counter plus strict-less-than best-candidate tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      BestDist <= DIST_MAX;
      motionX  <= '0;
      motionY  <= '0;
    end else if (!start) begin
      count <= '0;
    end else begin
      if (in_run) count <= count + CNT_W'(1);
      if (count == '0) begin
        BestDist <= DIST_MAX;
        motionX  <= '0;
        motionY  <= '0;
      end else if (cmp_valid && (cand < BestDist)) begin
        BestDist <= cand;
        motionX  <= cmp_k ^ 4'h8;
        motionY  <= cmp_dy ^ 4'h8;
      end
    end
  end

endmodule

// File: tb/tb_motion_estimator.sv
// Bench for motion_estimator: directed scenarios plus randomized data vs. a direct SAD search model.
module tb_motion_estimator;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] AddressR;
  logic [7:0] R;
  logic [9:0] AddressS1;
  logic [7:0] S1;
  logic [9:0] AddressS2;
  logic [7:0] S2;
  logic [7:0] BestDist;
  logic [3:0] motionX;
  logic [3:0] motionY;

  logic [7:0] ref_mem  [256];
  logic [7:0] srch_mem [1024];

  int checks   = 0;
  int failures = 0;

  assign R  = ref_mem[AddressR];
  assign S1 = srch_mem[AddressS1];
  assign S2 = srch_mem[AddressS2];

  motion_estimator dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .AddressR  (AddressR),
    .R         (R),
    .AddressS1 (AddressS1),
    .S1        (S1),
    .AddressS2 (AddressS2),
    .S2        (S2),
    .BestDist  (BestDist),
    .motionX   (motionX),
    .motionY   (motionY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Best SAD over every candidate whose result would be committed within 'limit' edges.
  task automatic model(input int limit, output logic [7:0] bd,
                       output logic [3:0] mx, output logic [3:0] my);
    int sad;
    int a;
    int b;
    bd = 8'hFF;
    mx = 4'h0;
    my = 4'h0;
    for (int dy = 0; dy < 16; dy++) begin
      for (int dx = 0; dx < 16; dx++) begin
        if ((dy + 1) * 256 + dx < limit) begin
          sad = 0;
          for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
              a = int'(ref_mem[i*16 + j]);
              b = int'(srch_mem[(dy + i)*32 + dx + j]);
              sad += (a > b) ? a - b : b - a;
            end
          end
          if (sad > 255) sad = 255;
          if (sad < int'(bd)) begin
            bd = 8'(sad);
            mx = 4'(dx - 8);
            my = 4'(dy - 8);
          end
        end
      end
    end
  endtask

  task automatic fill_low_amp();
    for (int n = 0; n < 256; n++)  ref_mem[n]  = 8'($urandom_range(0, 2));
    for (int n = 0; n < 1024; n++) srch_mem[n] = 8'($urandom_range(0, 2));
  endtask

  // Reference pixels stay in 0..63 and the window in 128..255, so non-copies differ by >= 64.
  task automatic fill_background();
    for (int n = 0; n < 256; n++)  ref_mem[n]  = 8'($urandom_range(0, 63));
    for (int n = 0; n < 1024; n++) srch_mem[n] = 8'($urandom_range(128, 255));
  endtask

  task automatic plant(input int dyi, input int dxi);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        srch_mem[(dyi + i)*32 + dxi + j] = ref_mem[i*16 + j];
  endtask

  // Hold start high for n edges starting from count 0, spot-checking the address generator.
  task automatic run_edges(input int n);
    int p;
    for (int c = 0; c < n; c++) begin
      if (c < 4096 && (c < 20 || (c % 97) == 0)) begin
        check("addr_r", 32'(AddressR), 32'(c & 255));
        check("addr_s1", 32'(AddressS1),
              32'((((c >> 8) & 15) + ((c >> 4) & 15)) * 32 + (c & 15)));
        if (c >= 16) begin
          p = c - 16;
          check("addr_s2", 32'(AddressS2),
                32'((((p >> 8) & 15) + ((p >> 4) & 15)) * 32 + 16 + (c & 15)));
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eb,
                           input logic [3:0] ex, input logic [3:0] ey);
    check({name, ".dist"}, 32'(BestDist), 32'(eb));
    check({name, ".mx"},   32'(motionX),  32'(ex));
    check({name, ".my"},   32'(motionY),  32'(ey));
  endtask

  task automatic run_full(input string name, input logic [7:0] eb,
                          input logic [3:0] ex, input logic [3:0] ey);
    start = 1'b1;
    run_edges(4112);
    check_out(name, eb, ex, ey);
    @(negedge clock);
    check_out({name, ".sat"}, eb, ex, ey);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_out({name, ".hold"}, eb, ex, ey);
  endtask

  task automatic run_model(input string name);
    logic [7:0] eb;
    logic [3:0] ex;
    logic [3:0] ey;
    model(4112, eb, ex, ey);
    run_full(name, eb, ex, ey);
  endtask

  initial begin
    logic [7:0] eb;
    logic [3:0] ex;
    logic [3:0] ey;
    int idx;

    reset = 1'b1;
    start = 1'b0;
    fill_low_amp();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_out("reset", 8'hFF, 4'h0, 4'h0);
    check("reset.addr_r", 32'(AddressR), 32'd0);

    // Exact copy at dx=3, dy=-2.
    fill_background();
    plant(6, 11);
    run_full("copy_p3_m2", 8'h00, 4'h3, 4'hE);

    // Copies at both extreme corners; the earlier candidate wins the tie.
    fill_background();
    ref_mem[255] = ref_mem[0];
    plant(0, 0);
    plant(15, 15);
    run_full("tie_corners", 8'h00, 4'h8, 4'h8);

    // Centre copy with one pixel off by 5.
    fill_background();
    plant(8, 8);
    idx = (8 + 5)*32 + 8 + 7;
    srch_mem[idx] = 8'(srch_mem[idx] + 8'd5);
    run_full("centre_plus5", 8'h05, 4'h0, 4'h0);

    // Every candidate saturates: no match.
    for (int n = 0; n < 256; n++)  ref_mem[n]  = 8'h00;
    for (int n = 0; n < 1024; n++) srch_mem[n] = 8'hFF;
    run_full("no_match", 8'hFF, 4'h0, 4'h0);

    // Low-amplitude random data: many near-ties, non-saturated sums.
    for (int r = 0; r < 3; r++) begin
      fill_low_amp();
      run_model($sformatf("rand%0d", r));
    end

    // Noisy copy at a random displacement on a fully random window.
    for (int n = 0; n < 256; n++)  ref_mem[n]  = 8'($urandom_range(0, 255));
    for (int n = 0; n < 1024; n++) srch_mem[n] = 8'($urandom_range(0, 255));
    plant(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    for (int n = 0; n < 20; n++) begin
      idx = int'($urandom_range(0, 1023));
      srch_mem[idx] = srch_mem[idx] ^ 8'($urandom_range(1, 3));
    end
    run_model("noisy_copy");

    // Reset in the middle of a run, start held high throughout.
    fill_low_amp();
    start = 1'b1;
    run_edges(2000);
    model(2000, eb, ex, ey);
    check_out("mid.partial", eb, ex, ey);
    reset = 1'b1;
    @(negedge clock);
    check_out("mid.reset", 8'hFF, 4'h0, 4'h0);
    check("mid.reset.addr_r", 32'(AddressR), 32'd0);
    reset = 1'b0;
    run_model("after_reset");

    // Start dropped at cycle 1000: abort, hold partial result, then a clean rerun.
    fill_low_amp();
    start = 1'b1;
    run_edges(1000);
    start = 1'b0;
    model(1000, eb, ex, ey);
    check_out("abort.partial", eb, ex, ey);
    repeat (5) @(negedge clock);
    check_out("abort.hold", eb, ex, ey);
    check("abort.addr_r", 32'(AddressR), 32'd0);
    run_model("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
